// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared types and constants for the FIFO access controller
//
// Purpose: FSM state encodings and the geometry of the attached FIFO
//          (4-bit words, 8 slots of which 7 are usable).
// Ports:   none (package).

package fifo_ctrl_pkg;

  localparam int FIFO_WIDTH = 4;
  localparam int FIFO_DEPTH = 7;
  localparam int LEVEL_W    = 3;

  typedef enum logic {
    P_IDLE,
    P_PUSH
  } push_state_t;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_POP,
    Q_RET
  } pop_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - stateless round-robin grant selection
//
// Purpose: picks the first asserted request at or after ptr, wrapping at NREQ.
//          The pointer register is owned by the caller.
// Ports:
//   req         in   NREQ  request vector
//   ptr         in   IW    highest-priority requester index
//   grant       out  NREQ  one-hot grant (all zero when no request)
//   grant_idx   out  IW    index of the granted requester
//   grant_valid out  1     at least one request present

module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_valid
);

  logic [IW-1:0] cand;

  // Walk the requesters in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!grant_valid && req[cand]) begin
        grant_valid     = 1'b1;
        grant_idx       = cand;
        grant[cand]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// rtl/fifo_access_ctrl.sv - shared push port and pulsed pop port for an 8-slot FIFO
//
// Purpose: arbitrates NREQ producers onto the FIFO write port with one-cycle
//          en_in pulses separated by a low gap, converts a level pop request
//          into en_out pulses returning the popped word, and tracks occupancy.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   req / req_data        per-producer push request and data (i at [i*WIDTH +: WIDTH])
//   ack                   one-hot pulse coinciding with the producer's write
//   pop_req               consumer pop request (level)
//   pop_valid / pop_data  one-cycle strobe and the popped word (held until next pop)
//   level                 entries currently held
//   fifo_en_in / fifo_in  FIFO write strobe and data
//   fifo_en_out           FIFO read strobe
//   fifo_out              FIFO read data
//   fifo_full/fifo_empty  FIFO status flags

module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  input  logic                  pop_req,
  output logic                  pop_valid,
  output logic [WIDTH-1:0]      pop_data,
  output logic [LEVEL_W-1:0]    level,
  output logic                  fifo_en_in,
  output logic [WIDTH-1:0]      fifo_in,
  output logic                  fifo_en_out,
  input  logic [WIDTH-1:0]      fifo_out,
  input  logic                  fifo_full,
  input  logic                  fifo_empty
);

  localparam int PTR_W = $clog2(NREQ);

  push_state_t p_state, p_state_d;
  pop_state_t  q_state, q_state_d;

  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [NREQ-1:0]    gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic [WIDTH-1:0]   win_data;

  logic               en_in_d;
  logic [NREQ-1:0]    ack_d;
  logic [WIDTH-1:0]   fifo_in_d;

  logic               en_out_d;
  logic               pop_valid_d;
  logic [WIDTH-1:0]   pop_data_d;

  logic [LEVEL_W-1:0] level_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (PTR_W)
  ) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (gnt),
    .grant_idx   (gnt_idx),
    .grant_valid (gnt_valid)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        win_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Push FSM: every push is followed by a P_PUSH cycle with en_in low, so the
  // FIFO sees a clean rising edge per word and flags are fresh at the next grant.
  always_comb begin
    p_state_d = p_state;
    en_in_d   = 1'b0;
    ack_d     = '0;
    fifo_in_d = fifo_in;
    rr_ptr_d  = rr_ptr;
    case (p_state)
      P_IDLE: begin
        if (gnt_valid && !fifo_full) begin
          en_in_d   = 1'b1;
          ack_d     = gnt;
          fifo_in_d = win_data;
          rr_ptr_d  = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          p_state_d = P_PUSH;
        end
      end
      P_PUSH: begin
        p_state_d = P_IDLE;
      end
      default: begin
        p_state_d = P_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_state    <= P_IDLE;
      rr_ptr     <= '0;
      fifo_en_in <= 1'b0;
      ack        <= '0;
      fifo_in    <= '0;
    end else begin
      p_state    <= p_state_d;
      rr_ptr     <= rr_ptr_d;
      fifo_en_in <= en_in_d;
      ack        <= ack_d;
      fifo_in    <= fifo_in_d;
    end
  end

  // Pop FSM: the FIFO presents the new word after the Q_POP cycle, so it is
  // captured in Q_RET rather than directly after the pulse.
  always_comb begin
    q_state_d   = q_state;
    en_out_d    = 1'b0;
    pop_valid_d = 1'b0;
    pop_data_d  = pop_data;
    case (q_state)
      Q_IDLE: begin
        if (pop_req && !fifo_empty) begin
          en_out_d  = 1'b1;
          q_state_d = Q_POP;
        end
      end
      Q_POP: begin
        q_state_d = Q_RET;
      end
      Q_RET: begin
        pop_valid_d = 1'b1;
        pop_data_d  = fifo_out;
        q_state_d   = Q_IDLE;
      end
      default: begin
        q_state_d = Q_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_state     <= Q_IDLE;
      fifo_en_out <= 1'b0;
      pop_valid   <= 1'b0;
      pop_data    <= '0;
    end else begin
      q_state     <= q_state_d;
      fifo_en_out <= en_out_d;
      pop_valid   <= pop_valid_d;
      pop_data    <= pop_data_d;
    end
  end

  // Level moves together with the pulse that causes it; a simultaneous push
  // and pop cancel. The bounds guards only matter if the flags disagree.
  always_comb begin
    level_d = level;
    if (en_in_d && !en_out_d && level != LEVEL_W'(DEPTH)) begin
      level_d = level + LEVEL_W'(1);
    end else if (en_out_d && !en_in_d && level != '0) begin
      level_d = level - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      level <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(en_in_d && !en_out_d && level == LEVEL_W'(DEPTH)));
      assert (!(en_out_d && !en_in_d && level == '0));
    end
  end

endmodule
